// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU and its divider core.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_OR   = 4'd0,
    OP_AND  = 4'd1,
    OP_NOT  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SHR  = 4'd5,
    OP_SHRA = 4'd6,
    OP_SHL  = 4'd7,
    OP_ROR  = 4'd8,
    OP_ROL  = 4'd9,
    OP_NEG  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } alu_state_t;

endpackage

// File: rtl/alu_div_nr.sv
// Iterative unsigned non-restoring divider: one quotient bit per cycle,
// WIDTH cycles after the start pulse. The remainder is corrected on the output
// side so the caller can read it in the cycle after done_o.
module alu_div_nr #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH+1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH+1:0] dvsExt, shifted, trial;

  // One non-restoring step per cycle: add or subtract the divisor depending on
  // the sign of the partial remainder, then shift the new quotient bit in.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    dvsExt   = {2'b00, dvs_q};
    shifted  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
    trial    = rem_q[WIDTH+1] ? (shifted + dvsExt) : (shifted - dvsExt);
    if (start_i) begin
      rem_d    = '0;
      quo_d    = dividend_i;
      dvs_d    = divisor_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rem_d = trial;
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SHW'(WIDTH - 1)) begin
        active_d = 1'b0;
      end
    end
  end

  // Iteration registers, cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o      = active_q && (cnt_q == SHW'(WIDTH - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q[WIDTH+1] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake: logic, arithmetic, shifts and
// rotates in one cycle, Booth multiply into HI/LO, signed divide via alu_div_nr.
// Build option: define ALU_BOOTH4_EN for a radix-4 Booth multiplier (WIDTH/2 steps).
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);
`ifdef ALU_BOOTH4_EN
  localparam int MUL_ITERS = WIDTH / 2;
`else
  localparam int MUL_ITERS = WIDTH;
`endif

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             zero_q, zero_d, dbz_q, dbz_d;
  logic [WIDTH+1:0] mulAcc_q, mulAcc_d;
  logic [WIDTH-1:0] mulQ_q, mulQ_d, mulM_q, mulM_d;
  logic             mulQm1_q, mulQm1_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             aSign_q, aSign_d, bSign_q, bSign_d;
  logic [WIDTH+1:0] mExt, boothAdd, boothSum, boothAcc;
  logic [WIDTH-1:0] boothQ;
  logic             boothQm1;
  logic             divStart, divDone;
  logic [WIDTH-1:0] divQuo, divRem, aMag, bMag;

  function automatic logic [WIDTH-1:0] singleOp(input logic [OP_W-1:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [SHW-1:0]     s;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   r;
    s   = y[SHW-1:0];
    dbl = {x, x};
    case (o)
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_NOT:  r = ~x;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SHR:  r = x >> s;
      OP_SHRA: r = $unsigned($signed(x) >>> s);
      OP_SHL:  r = x << s;
      OP_ROR:  begin dbl = dbl >> s; r = dbl[WIDTH-1:0]; end
      OP_ROL:  begin dbl = dbl << s; r = dbl[2*WIDTH-1:WIDTH]; end
      OP_NEG:  r = '0 - x;
      default: r = x;
    endcase
    return r;
  endfunction

  assign aMag = a[WIDTH-1] ? ('0 - a) : a;
  assign bMag = b[WIDTH-1] ? ('0 - b) : b;

  alu_div_nr #(.WIDTH(WIDTH)) u_div (
    .clock       (clock),
    .clear_n     (clear_n),
    .start_i     (divStart),
    .dividend_i  (aMag),
    .divisor_i   (bMag),
    .quotient_o  (divQuo),
    .remainder_o (divRem),
    .done_o      (divDone)
  );

  // One Booth step on the multiplier registers: add/subtract the recoded
  // multiple of the multiplicand, then arithmetic-shift the accumulator pair.
  always_comb begin
    mExt = {{2{mulM_q[WIDTH-1]}}, mulM_q};
`ifdef ALU_BOOTH4_EN
    case ({mulQ_q[1:0], mulQm1_q})
      3'b001, 3'b010: boothAdd = mExt;
      3'b011:         boothAdd = mExt << 1;
      3'b100:         boothAdd = '0 - (mExt << 1);
      3'b101, 3'b110: boothAdd = '0 - mExt;
      default:        boothAdd = '0;
    endcase
    boothSum = mulAcc_q + boothAdd;
    boothAcc = {{2{boothSum[WIDTH+1]}}, boothSum[WIDTH+1:2]};
    boothQ   = {boothSum[1:0], mulQ_q[WIDTH-1:2]};
    boothQm1 = mulQ_q[1];
`else
    case ({mulQ_q[0], mulQm1_q})
      2'b01:   boothAdd = mExt;
      2'b10:   boothAdd = '0 - mExt;
      default: boothAdd = '0;
    endcase
    boothSum = mulAcc_q + boothAdd;
    boothAcc = {boothSum[WIDTH+1], boothSum[WIDTH+1:1]};
    boothQ   = {boothSum[0], mulQ_q[WIDTH-1:1]};
    boothQm1 = mulQ_q[0];
`endif
  end

  // Next-state logic: accept a request in IDLE, iterate MUL/DIV, apply the
  // quotient/remainder signs in FIX, and load the result registers at the
  // step that completes the operation so they stay frozen while busy.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    mulAcc_d = mulAcc_q;
    mulQ_d   = mulQ_q;
    mulQm1_d = mulQm1_q;
    mulM_d   = mulM_q;
    cnt_d    = cnt_q;
    aSign_d  = aSign_q;
    bSign_d  = bSign_q;
    divStart = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          aSign_d = a[WIDTH-1];
          bSign_d = b[WIDTH-1];
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mulAcc_d = '0;
            mulQ_d   = a;
            mulQm1_d = 1'b0;
            mulM_d   = b;
            cnt_d    = '0;
          end else if (op == OP_DIV) begin
            if (b == '0) begin
              state_d = S_DONE;
              lo_d    = '1;
              hi_d    = a;
              zero_d  = 1'b0;
              dbz_d   = 1'b1;
            end else begin
              state_d  = S_DIV;
              divStart = 1'b1;
            end
          end else begin
            state_d = S_DONE;
            lo_d    = singleOp(op, a, b);
            hi_d    = '0;
            zero_d  = (lo_d == '0);
            dbz_d   = 1'b0;
          end
        end
      end
      S_MUL: begin
        mulAcc_d = boothAcc;
        mulQ_d   = boothQ;
        mulQm1_d = boothQm1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(MUL_ITERS - 1)) begin
          state_d = S_DONE;
          lo_d    = boothQ;
          hi_d    = boothAcc[WIDTH-1:0];
          zero_d  = (boothQ == '0);
          dbz_d   = 1'b0;
        end
      end
      S_DIV: begin
        if (divDone) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        lo_d    = (aSign_q ^ bSign_q) ? ('0 - divQuo) : divQuo;
        hi_d    = aSign_q ? ('0 - divRem) : divRem;
        zero_d  = (lo_d == '0);
        dbz_d   = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      mulAcc_q <= '0;
      mulQ_q   <= '0;
      mulQm1_q <= 1'b0;
      mulM_q   <= '0;
      cnt_q    <= '0;
      aSign_q  <= 1'b0;
      bSign_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      mulAcc_q <= mulAcc_d;
      mulQ_q   <= mulQ_d;
      mulQm1_q <= mulQm1_d;
      mulM_q   <= mulM_d;
      cnt_q    <= cnt_d;
      aSign_q  <= aSign_d;
      bSign_q  <= bSign_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign result_lo   = lo_q;
  assign result_hi   = hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule
